// File: rtl/axi4_mem_rw_bridge.sv
// AXI4 slave front end for the simulation RAM helper.
// Bursts are broken into single 64-bit beats addressed by a helper index
// ((addr - MEM_BASE) >> 3). Read and write channels run independently.
//
// Read FSM
//   state   | meaning
//   R_IDLE  | arready high, waiting for an AR handshake
//   R_ISSUE | helper read strobe for the current beat (suppressed on error)
//   R_DATA  | rvalid high, rdata taken from the helper's held read data
//
// Write FSM
//   state   | meaning
//   W_IDLE  | awready high, waiting for an AW handshake
//   W_DATA  | wready high, each accepted beat is written straight through
//   W_RESP  | bvalid high, waiting for bready
module axi4_mem_rw_bridge #(
    parameter int          ID_WIDTH   = 4,
    parameter int          ADDR_WIDTH = 48,
    parameter logic [63:0] MEM_BASE   = 64'h8000_0000
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  awvalid,
    output logic                  awready,
    input  logic [ID_WIDTH-1:0]   awid,
    input  logic [ADDR_WIDTH-1:0] awaddr,
    input  logic [7:0]            awlen,
    input  logic [2:0]            awsize,
    input  logic [1:0]            awburst,
    input  logic                  wvalid,
    output logic                  wready,
    input  logic [63:0]           wdata,
    input  logic [7:0]            wstrb,
    input  logic                  wlast,
    output logic                  bvalid,
    input  logic                  bready,
    output logic [ID_WIDTH-1:0]   bid,
    output logic [1:0]            bresp,
    input  logic                  arvalid,
    output logic                  arready,
    input  logic [ID_WIDTH-1:0]   arid,
    input  logic [ADDR_WIDTH-1:0] araddr,
    input  logic [7:0]            arlen,
    input  logic [2:0]            arsize,
    input  logic [1:0]            arburst,
    output logic                  rvalid,
    input  logic                  rready,
    output logic [ID_WIDTH-1:0]   rid,
    output logic [63:0]           rdata,
    output logic [1:0]            rresp,
    output logic                  rlast,
    output logic                  mem_enable,
    output logic                  mem_r_enable,
    output logic [63:0]           mem_r_index,
    input  logic [63:0]           mem_r_data,
    output logic                  mem_w_enable,
    output logic [63:0]           mem_w_index,
    output logic [63:0]           mem_w_data,
    output logic [63:0]           mem_w_mask
);

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    localparam logic [1:0] BURST_FIXED = 2'd0;
    localparam logic [1:0] BURST_WRAP  = 2'd2;
    localparam logic [1:0] BURST_RSVD  = 2'd3;

    typedef enum logic [1:0] {R_IDLE, R_ISSUE, R_DATA} r_state_t;
    typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_t;

    // Response code for a whole burst, decided once at address acceptance.
    // Below-base addresses take priority over unsupported size/burst shapes.
    function automatic logic [1:0] burst_code(input logic [ADDR_WIDTH-1:0] addr,
                                              input logic [2:0] size,
                                              input logic [1:0] burst,
                                              input logic [7:0] len);
        if (64'(addr) < MEM_BASE)
            return RESP_DECERR;
        if (size != 3'd3 || burst == BURST_RSVD)
            return RESP_SLVERR;
        if (burst == BURST_WRAP && len != 8'd1 && len != 8'd3 && len != 8'd7 && len != 8'd15)
            return RESP_SLVERR;
        return RESP_OKAY;
    endfunction

    function automatic logic [63:0] to_index(input logic [ADDR_WIDTH-1:0] addr);
        return (64'(addr) - MEM_BASE) >> 3;
    endfunction

    // WRAP lengths are 2^n-1, so len itself is the mask of the wrapping bits.
    function automatic logic [63:0] next_index(input logic [63:0] idx,
                                               input logic [1:0]  burst,
                                               input logic [7:0]  len);
        logic [63:0] wmask;
        wmask = {56'd0, len};
        case (burst)
            BURST_FIXED: return idx;
            BURST_WRAP:  return (idx & ~wmask) | ((idx + 64'd1) & wmask);
            default:     return idx + 64'd1;
        endcase
    endfunction

    r_state_t              r_rstate;
    logic                  r_arready;
    logic                  r_mem_r_enable;
    logic                  r_rvalid;
    logic                  r_rlast;
    logic [ID_WIDTH-1:0]   r_rid;
    logic [1:0]            r_rresp;
    logic [63:0]           r_rindex;
    logic [7:0]            r_rlen;
    logic [7:0]            r_rbeat;
    logic [1:0]            r_rburst;

    w_state_t              r_wstate;
    logic                  r_awready;
    logic                  r_wready;
    logic                  r_bvalid;
    logic [ID_WIDTH-1:0]   r_wid;
    logic [1:0]            r_bresp;
    logic [1:0]            r_werr;
    logic [63:0]           r_windex;
    logic [7:0]            r_wlen;
    logic [7:0]            r_wbeat;
    logic                  r_wover;
    logic [1:0]            r_wburst;

    logic                  w_wr_fire;
    logic [63:0]           w_byte_mask;

    // Read channel: one helper read per beat, data presented the cycle after.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_rstate       <= R_IDLE;
            r_arready      <= 1'b0;
            r_mem_r_enable <= 1'b0;
            r_rvalid       <= 1'b0;
            r_rlast        <= 1'b0;
            r_rid          <= '0;
            r_rresp        <= RESP_OKAY;
            r_rindex       <= 64'd0;
            r_rlen         <= 8'd0;
            r_rbeat        <= 8'd0;
            r_rburst       <= 2'd0;
        end else begin
            case (r_rstate)
                R_IDLE: begin
                    r_arready <= 1'b1;
                    if (arvalid && r_arready) begin
                        r_arready      <= 1'b0;
                        r_rid          <= arid;
                        r_rindex       <= to_index(araddr);
                        r_rlen         <= arlen;
                        r_rbeat        <= 8'd0;
                        r_rburst       <= arburst;
                        r_rresp        <= burst_code(araddr, arsize, arburst, arlen);
                        r_mem_r_enable <= (burst_code(araddr, arsize, arburst, arlen) == RESP_OKAY);
                        r_rstate       <= R_ISSUE;
                    end
                end
                R_ISSUE: begin
                    r_mem_r_enable <= 1'b0;
                    r_rvalid       <= 1'b1;
                    r_rlast        <= (r_rbeat == r_rlen);
                    r_rstate       <= R_DATA;
                end
                R_DATA: begin
                    if (rready) begin
                        r_rvalid <= 1'b0;
                        r_rlast  <= 1'b0;
                        if (r_rlast) begin
                            r_arready <= 1'b1;
                            r_rstate  <= R_IDLE;
                        end else begin
                            r_rindex       <= next_index(r_rindex, r_rburst, r_rlen);
                            r_rbeat        <= r_rbeat + 8'd1;
                            r_mem_r_enable <= (r_rresp == RESP_OKAY);
                            r_rstate       <= R_ISSUE;
                        end
                    end
                end
                default: r_rstate <= R_IDLE;
            endcase
        end
    end

    // Write channel: beats past awlen are swallowed (r_wover) until wlast.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_wstate  <= W_IDLE;
            r_awready <= 1'b0;
            r_wready  <= 1'b0;
            r_bvalid  <= 1'b0;
            r_wid     <= '0;
            r_bresp   <= RESP_OKAY;
            r_werr    <= RESP_OKAY;
            r_windex  <= 64'd0;
            r_wlen    <= 8'd0;
            r_wbeat   <= 8'd0;
            r_wover   <= 1'b0;
            r_wburst  <= 2'd0;
        end else begin
            case (r_wstate)
                W_IDLE: begin
                    r_awready <= 1'b1;
                    if (awvalid && r_awready) begin
                        r_awready <= 1'b0;
                        r_wready  <= 1'b1;
                        r_wid     <= awid;
                        r_windex  <= to_index(awaddr);
                        r_wlen    <= awlen;
                        r_wburst  <= awburst;
                        r_werr    <= burst_code(awaddr, awsize, awburst, awlen);
                        r_wbeat   <= 8'd0;
                        r_wover   <= 1'b0;
                        r_wstate  <= W_DATA;
                    end
                end
                W_DATA: begin
                    if (wvalid && r_wready) begin
                        r_windex <= next_index(r_windex, r_wburst, r_wlen);
                        if (!r_wover) begin
                            if (r_wbeat == r_wlen)
                                r_wover <= 1'b1;
                            else
                                r_wbeat <= r_wbeat + 8'd1;
                        end
                        if (wlast) begin
                            r_wready <= 1'b0;
                            r_bvalid <= 1'b1;
                            if (r_werr != RESP_OKAY)
                                r_bresp <= r_werr;
                            else if (r_wover || r_wbeat != r_wlen)
                                r_bresp <= RESP_SLVERR;
                            else
                                r_bresp <= RESP_OKAY;
                            r_wstate <= W_RESP;
                        end
                    end
                end
                W_RESP: begin
                    if (bready) begin
                        r_bvalid  <= 1'b0;
                        r_awready <= 1'b1;
                        r_wstate  <= W_IDLE;
                    end
                end
                default: r_wstate <= W_IDLE;
            endcase
        end
    end

    // Expand byte strobes to a bit mask for the helper.
    always_comb begin
        w_byte_mask = 64'd0;
        for (int i = 0; i < 8; i++)
            w_byte_mask[8*i +: 8] = {8{wstrb[i]}};
    end

    assign w_wr_fire    = r_wready & wvalid & (r_werr == RESP_OKAY) & ~r_wover;

    assign mem_enable   = ~reset;
    assign mem_r_enable = r_mem_r_enable;
    assign mem_r_index  = r_rindex;
    assign mem_w_enable = w_wr_fire;
    assign mem_w_index  = r_windex;
    assign mem_w_data   = w_wr_fire ? wdata : 64'd0;
    assign mem_w_mask   = w_wr_fire ? w_byte_mask : 64'd0;

    assign arready      = r_arready;
    assign rvalid       = r_rvalid;
    assign rlast        = r_rlast;
    assign rid          = r_rid;
    assign rresp        = r_rresp;
    assign rdata        = (r_rvalid && r_rresp == RESP_OKAY) ? mem_r_data : 64'd0;

    assign awready      = r_awready;
    assign wready       = r_wready;
    assign bvalid       = r_bvalid;
    assign bid          = r_wid;
    assign bresp        = r_bresp;

endmodule

// File: tb/tb_axi4_mem_rw_bridge.sv
// Bench for axi4_mem_rw_bridge: behavioural helper RAM plus a reference
// memory and burst-index model driven from the protocol rules.
module tb_axi4_mem_rw_bridge;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        awvalid = 0, wvalid = 0, wlast = 0, bready = 0, arvalid = 0, rready = 0;
    logic        awready, wready, bvalid, arready, rvalid, rlast;
    logic [3:0]  awid = 0, arid = 0, bid, rid;
    logic [47:0] awaddr = 0, araddr = 0;
    logic [7:0]  awlen = 0, arlen = 0, wstrb = 0;
    logic [2:0]  awsize = 0, arsize = 0;
    logic [1:0]  awburst = 0, arburst = 0, bresp, rresp;
    logic [63:0] wdata = 0, rdata;
    logic        mem_enable, mem_r_enable, mem_w_enable;
    logic [63:0] mem_r_index, mem_r_data, mem_w_index, mem_w_data, mem_w_mask;

    int errors = 0;
    int checks = 0;
    int rd_en_cnt = 0;
    int wr_en_cnt = 0;

    logic [63:0] hmem    [logic [63:0]];
    logic [63:0] ref_mem [logic [63:0]];
    logic [63:0] hm_old;

    axi4_mem_rw_bridge dut (
        .clock(clock), .reset(reset),
        .awvalid(awvalid), .awready(awready), .awid(awid), .awaddr(awaddr),
        .awlen(awlen), .awsize(awsize), .awburst(awburst),
        .wvalid(wvalid), .wready(wready), .wdata(wdata), .wstrb(wstrb), .wlast(wlast),
        .bvalid(bvalid), .bready(bready), .bid(bid), .bresp(bresp),
        .arvalid(arvalid), .arready(arready), .arid(arid), .araddr(araddr),
        .arlen(arlen), .arsize(arsize), .arburst(arburst),
        .rvalid(rvalid), .rready(rready), .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast),
        .mem_enable(mem_enable),
        .mem_r_enable(mem_r_enable), .mem_r_index(mem_r_index), .mem_r_data(mem_r_data),
        .mem_w_enable(mem_w_enable), .mem_w_index(mem_w_index),
        .mem_w_data(mem_w_data), .mem_w_mask(mem_w_mask)
    );

    always #5 clock = ~clock;

    initial begin
        #400000;
        $display("FAIL watchdog expired got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    function automatic logic [63:0] init_val(input logic [63:0] idx);
        return {idx[31:0] ^ 32'hA5A5_0000, ~idx[31:0]};
    endfunction

    function automatic logic [63:0] ref_read(input logic [63:0] idx);
        return ref_mem.exists(idx) ? ref_mem[idx] : init_val(idx);
    endfunction

    // Helper RAM: registered read that holds its output, masked write.
    always @(posedge clock) begin
        if (mem_r_enable) begin
            mem_r_data <= hmem.exists(mem_r_index) ? hmem[mem_r_index] : init_val(mem_r_index);
            rd_en_cnt++;
        end
        if (mem_w_enable) begin
            hm_old = hmem.exists(mem_w_index) ? hmem[mem_w_index] : init_val(mem_w_index);
            hmem[mem_w_index] = (hm_old & ~mem_w_mask) | (mem_w_data & mem_w_mask);
            wr_en_cnt++;
        end
    end

    function automatic logic [1:0] exp_err(input logic [47:0] a, input logic [2:0] s,
                                           input logic [1:0] bt, input logic [7:0] l);
        if ({16'h0, a} < 64'h8000_0000) return 2'd3;
        if (s != 3'd3 || bt == 2'd3) return 2'd2;
        if (bt == 2'd2 && l != 8'd1 && l != 8'd3 && l != 8'd7 && l != 8'd15) return 2'd2;
        return 2'd0;
    endfunction

    function automatic logic [63:0] start_index(input logic [47:0] a);
        return ({16'h0, a} - 64'h8000_0000) / 8;
    endfunction

    function automatic logic [63:0] exp_index(input logic [63:0] st, input logic [1:0] bt,
                                              input logic [7:0] l, input int b);
        logic [63:0] blk, base;
        if (bt == 2'd0) return st;
        if (bt == 2'd2) begin
            blk  = 64'(l) + 64'd1;
            base = st - (st % blk);
            return base + ((st - base + 64'(b)) % blk);
        end
        return st + 64'(b);
    endfunction

    function automatic logic [63:0] strb_to_mask(input logic [7:0] s);
        logic [63:0] m;
        m = 64'd0;
        for (int i = 0; i < 8; i++)
            if (s[i]) m = m | (64'hFF << (8 * i));
        return m;
    endfunction

    task automatic wait_ar();
        int to;
        to = 0;
        while (arready !== 1'b1 && to < 50) begin @(negedge clock); to++; end
        if (to >= 50) begin
            errors++;
            $display("FAIL ar_wait got arready=%b exp=1 within 50 cycles", arready);
        end
        checks++;
    endtask

    task automatic wait_aw();
        int to;
        to = 0;
        while (awready !== 1'b1 && to < 50) begin @(negedge clock); to++; end
        if (to >= 50) begin
            errors++;
            $display("FAIL aw_wait got awready=%b exp=1 within 50 cycles", awready);
        end
        checks++;
    endtask

    task automatic do_read(input logic [47:0] addr, input logic [7:0] len, input logic [2:0] size,
                           input logic [1:0] bt, input logic [3:0] id,
                           input int stall_beat, input int stall_len);
        logic [1:0]  er;
        logic [63:0] st, idx, exp_d;
        logic        el;
        int          en0;
        er = exp_err(addr, size, bt, len);
        st = start_index(addr);
        araddr = addr; arlen = len; arsize = size; arburst = bt; arid = id; arvalid = 1'b1;
        wait_ar();
        en0 = rd_en_cnt;
        @(negedge clock);
        arvalid = 1'b0;
        for (int b = 0; b <= int'(len); b++) begin
            idx = exp_index(st, bt, len, b);
            checks++;
            if (mem_r_enable !== (er == 2'd0) || (er == 2'd0 && mem_r_index !== idx)) begin
                errors++;
                $display("FAIL rd_issue beat%0d got en=%b idx=%0d exp en=%b idx=%0d",
                         b, mem_r_enable, mem_r_index, (er == 2'd0), idx);
            end
            exp_d = (er == 2'd0) ? ref_read(idx) : 64'd0;
            el = (b == int'(len));
            @(negedge clock);
            for (int s = 0; s <= ((b == stall_beat) ? stall_len : 0); s++) begin
                if (s > 0) @(negedge clock);
                checks++;
                if (rvalid !== 1'b1 || rdata !== exp_d || rresp !== er || rlast !== el ||
                    rid !== id || mem_r_enable !== 1'b0) begin
                    errors++;
                    $display("FAIL rd_beat%0d wait%0d got v=%b d=%h resp=%0d last=%b id=%0h ren=%b exp v=1 d=%h resp=%0d last=%b id=%0h ren=0",
                             b, s, rvalid, rdata, rresp, rlast, rid, mem_r_enable, exp_d, er, el, id);
                end
            end
            rready = 1'b1;
            @(negedge clock);
            rready = 1'b0;
        end
        checks++;
        if (arready !== 1'b1 || rvalid !== 1'b0) begin
            errors++;
            $display("FAIL rd_end got arready=%b rvalid=%b exp arready=1 rvalid=0", arready, rvalid);
        end
        checks++;
        if (rd_en_cnt - en0 != ((er == 2'd0) ? int'(len) + 1 : 0)) begin
            errors++;
            $display("FAIL rd_enable_count got=%0d exp=%0d", rd_en_cnt - en0,
                     (er == 2'd0) ? int'(len) + 1 : 0);
        end
    endtask

    task automatic do_write(input logic [47:0] addr, input logic [7:0] len, input logic [2:0] size,
                            input logic [1:0] bt, input logic [3:0] id, input int nbeats,
                            input int sp_beat, input logic [7:0] sp_strb, input int bstall);
        logic [1:0]  er, eresp;
        logic [63:0] st, idx, m;
        logic        wr;
        int          en0, nwr;
        er = exp_err(addr, size, bt, len);
        st = start_index(addr);
        awaddr = addr; awlen = len; awsize = size; awburst = bt; awid = id; awvalid = 1'b1;
        wait_aw();
        en0 = wr_en_cnt;
        @(negedge clock);
        awvalid = 1'b0;
        nwr = 0;
        for (int b = 0; b < nbeats; b++) begin
            if ($urandom_range(0, 3) == 0) begin
                wvalid = 1'b0;
                #1;
                checks++;
                if (mem_w_enable !== 1'b0 || wready !== 1'b1) begin
                    errors++;
                    $display("FAIL wr_gap got wen=%b wready=%b exp wen=0 wready=1", mem_w_enable, wready);
                end
                @(negedge clock);
            end
            wvalid = 1'b1;
            wdata  = {$urandom, $urandom};
            wstrb  = (b == sp_beat) ? sp_strb : 8'($urandom);
            wlast  = (b == nbeats - 1);
            #1;
            wr  = (er == 2'd0) && (b <= int'(len));
            idx = exp_index(st, bt, len, b);
            m   = strb_to_mask(wstrb);
            checks++;
            if (wready !== 1'b1 || mem_w_enable !== wr ||
                (wr && (mem_w_index !== idx || mem_w_data !== wdata || mem_w_mask !== m))) begin
                errors++;
                $display("FAIL wr_beat%0d got rdy=%b en=%b idx=%0d d=%h m=%h exp rdy=1 en=%b idx=%0d d=%h m=%h",
                         b, wready, mem_w_enable, mem_w_index, mem_w_data, mem_w_mask, wr, idx, wdata, m);
            end
            if (wr) begin
                ref_mem[idx] = (ref_read(idx) & ~m) | (wdata & m);
                nwr++;
            end
            @(negedge clock);
        end
        wvalid = 1'b0; wlast = 1'b0;
        eresp = (er != 2'd0) ? er : ((nbeats - 1 != int'(len)) ? 2'd2 : 2'd0);
        for (int s = 0; s <= bstall; s++) begin
            if (s > 0) @(negedge clock);
            checks++;
            if (bvalid !== 1'b1 || bresp !== eresp || bid !== id || wready !== 1'b0) begin
                errors++;
                $display("FAIL wr_bresp wait%0d got bv=%b resp=%0d id=%0h wready=%b exp bv=1 resp=%0d id=%0h wready=0",
                         s, bvalid, bresp, bid, wready, eresp, id);
            end
        end
        bready = 1'b1;
        @(negedge clock);
        bready = 1'b0;
        checks++;
        if (bvalid !== 1'b0 || awready !== 1'b1) begin
            errors++;
            $display("FAIL wr_end got bvalid=%b awready=%b exp bvalid=0 awready=1", bvalid, awready);
        end
        checks++;
        if (wr_en_cnt - en0 != nwr) begin
            errors++;
            $display("FAIL wr_enable_count got=%0d exp=%0d", wr_en_cnt - en0, nwr);
        end
    endtask

    task automatic test_reset();
        @(negedge clock);
        checks++;
        if (arready !== 0 || awready !== 0 || wready !== 0 || rvalid !== 0 || bvalid !== 0 ||
            mem_r_enable !== 0 || mem_w_enable !== 0 || mem_enable !== 0 || rdata !== 0 ||
            rid !== 0 || rresp !== 0 || bresp !== 0 || bid !== 0 || rlast !== 0) begin
            errors++;
            $display("FAIL reset_state got ar=%b aw=%b w=%b rv=%b bv=%b ren=%b wen=%b men=%b rd=%h exp all 0",
                     arready, awready, wready, rvalid, bvalid, mem_r_enable, mem_w_enable, mem_enable, rdata);
        end
        reset = 1'b0;
        #1;
        checks++;
        if (arready !== 0 || awready !== 0 || mem_enable !== 1) begin
            errors++;
            $display("FAIL reset_release got ar=%b aw=%b men=%b exp ar=0 aw=0 men=1", arready, awready, mem_enable);
        end
        @(negedge clock);
        checks++;
        if (arready !== 1 || awready !== 1 || wready !== 0) begin
            errors++;
            $display("FAIL ready_after_reset got ar=%b aw=%b w=%b exp ar=1 aw=1 w=0", arready, awready, wready);
        end
    endtask

    task automatic test_single_read();
        do_read(48'h8000_0040, 8'd0, 3'd3, 2'd1, 4'h5, -1, 0);
    endtask

    task automatic test_incr_write();
        do_write(48'h8000_0000, 8'd3, 3'd3, 2'd1, 4'hA, 4, 2, 8'h0F, 1);
        do_read(48'h8000_0000, 8'd3, 3'd3, 2'd1, 4'h1, -1, 0);
    endtask

    task automatic test_wrap_read();
        do_read(48'h8000_0030, 8'd3, 3'd3, 2'd2, 4'h3, -1, 0);
        do_read(48'h8000_0068, 8'd7, 3'd3, 2'd2, 4'h4, 3, 2);
        do_read(48'h8000_0070, 8'd2, 3'd3, 2'd0, 4'h6, -1, 0);
    endtask

    task automatic test_errors();
        do_read(48'h7000_0000, 8'd1, 3'd3, 2'd1, 4'h7, -1, 0);
        do_read(48'h8000_0000, 8'd1, 3'd3, 2'd3, 4'h8, -1, 0);
        do_read(48'h8000_0000, 8'd2, 3'd3, 2'd2, 4'h8, -1, 0);
        do_write(48'h8000_0080, 8'd1, 3'd2, 2'd1, 4'h9, 2, -1, 8'h00, 0);
        do_write(48'h8000_00C0, 8'd3, 3'd3, 2'd1, 4'hB, 2, -1, 8'h00, 0);
        do_write(48'h8000_0100, 8'd1, 3'd3, 2'd1, 4'hC, 4, -1, 8'h00, 0);
        do_write(48'h6000_0000, 8'd0, 3'd3, 2'd1, 4'hD, 1, -1, 8'h00, 0);
        do_read(48'h8000_00C0, 8'd3, 3'd3, 2'd1, 4'h2, -1, 0);
    endtask

    task automatic test_backpressure();
        do_read(48'h8000_0000, 8'd3, 3'd3, 2'd1, 4'hE, 1, 5);
    endtask

    task automatic test_w_waits_for_aw();
        wvalid = 1'b1; wdata = 64'hDEAD_BEEF_0000_1111; wstrb = 8'hFF; wlast = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clock);
            checks++;
            if (wready !== 1'b0 || mem_w_enable !== 1'b0) begin
                errors++;
                $display("FAIL w_before_aw cyc%0d got wready=%b wen=%b exp 0 0", i, wready, mem_w_enable);
            end
        end
        wvalid = 1'b0; wlast = 1'b0;
    endtask

    task automatic test_concurrent();
        logic [63:0] idx, old_v, new_v;
        idx   = 64'd32;
        new_v = {$urandom, $urandom};
        awaddr = 48'h8000_0100; awlen = 0; awsize = 3; awburst = 1; awid = 4'h1; awvalid = 1'b1;
        wait_aw();
        @(negedge clock);
        awvalid = 1'b0;
        araddr = 48'h8000_0100; arlen = 0; arsize = 3; arburst = 1; arid = 4'h2; arvalid = 1'b1;
        wait_ar();
        @(negedge clock);
        arvalid = 1'b0;
        old_v = ref_read(idx);
        wvalid = 1'b1; wdata = new_v; wstrb = 8'hFF; wlast = 1'b1;
        #1;
        checks++;
        if (mem_r_enable !== 1'b1 || mem_w_enable !== 1'b1 || mem_w_index !== idx || mem_r_index !== idx) begin
            errors++;
            $display("FAIL same_cycle_rw got ren=%b wen=%b ridx=%0d widx=%0d exp 1 1 %0d %0d",
                     mem_r_enable, mem_w_enable, mem_r_index, mem_w_index, idx, idx);
        end
        ref_mem[idx] = new_v;
        @(negedge clock);
        wvalid = 1'b0; wlast = 1'b0;
        checks++;
        if (rvalid !== 1'b1 || rdata !== old_v || bvalid !== 1'b1 || bresp !== 2'd0) begin
            errors++;
            $display("FAIL rw_old_data got rv=%b d=%h bv=%b bresp=%0d exp rv=1 d=%h bv=1 bresp=0",
                     rvalid, rdata, bvalid, bresp, old_v);
        end
        rready = 1'b1; bready = 1'b1;
        @(negedge clock);
        rready = 1'b0; bready = 1'b0;
        do_read(48'h8000_0100, 8'd0, 3'd3, 2'd1, 4'h3, -1, 0);
    endtask

    task automatic test_reset_mid_burst();
        int en0;
        araddr = 48'h8000_0200; arlen = 7; arsize = 3; arburst = 1; arid = 4'h4; arvalid = 1'b1;
        wait_ar();
        @(negedge clock);
        arvalid = 1'b0;
        for (int b = 0; b < 2; b++) begin
            @(negedge clock);
            rready = 1'b1;
            @(negedge clock);
            rready = 1'b0;
        end
        @(negedge clock);
        checks++;
        if (rvalid !== 1'b1 || rdata !== ref_read(64'd66)) begin
            errors++;
            $display("FAIL beat2_before_reset got rv=%b d=%h exp rv=1 d=%h", rvalid, rdata, ref_read(64'd66));
        end
        reset = 1'b1;
        en0 = rd_en_cnt;
        @(negedge clock);
        checks++;
        if (rvalid !== 1'b0 || arready !== 1'b0 || mem_r_enable !== 1'b0 || mem_enable !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid_burst got rv=%b ar=%b ren=%b men=%b exp 0 0 0 0",
                     rvalid, arready, mem_r_enable, mem_enable);
        end
        @(negedge clock);
        reset = 1'b0;
        #1;
        checks++;
        if (arready !== 1'b0) begin
            errors++;
            $display("FAIL arready_at_release got=%b exp=0", arready);
        end
        @(negedge clock);
        checks++;
        if (arready !== 1'b1 || rvalid !== 1'b0 || rd_en_cnt != en0) begin
            errors++;
            $display("FAIL after_reset_release got ar=%b rv=%b extra_reads=%0d exp ar=1 rv=0 extra_reads=0",
                     arready, rvalid, rd_en_cnt - en0);
        end
        do_read(48'h8000_0200, 8'd3, 3'd3, 2'd1, 4'h5, -1, 0);
    endtask

    task automatic test_random();
        logic [47:0] a;
        logic [7:0]  l;
        logic [2:0]  sz;
        logic [1:0]  bt;
        int          kind, nb;
        for (int n = 0; n < 40; n++) begin
            bt = 2'($urandom_range(0, 2));
            if (bt == 2'd2) l = 8'((1 << $urandom_range(1, 4)) - 1);
            else            l = 8'($urandom_range(0, 7));
            a  = 48'h8000_0000 + 48'($urandom_range(0, 100) * 8) + 48'($urandom_range(0, 7));
            sz = 3'd3;
            kind = $urandom_range(0, 9);
            if (kind == 0) a  = 48'h4000_0000 + 48'($urandom_range(0, 255));
            if (kind == 1) sz = 3'($urandom_range(0, 2));
            if (kind == 2) bt = 2'd3;
            if ($urandom_range(0, 1) == 0) begin
                do_read(a, l, sz, bt, 4'($urandom), $urandom_range(0, int'(l)), $urandom_range(0, 3));
            end else begin
                nb = int'(l) + 1;
                if (kind == 3) nb = int'(l) + 2;
                if (kind == 4 && l > 0) nb = int'(l);
                do_write(a, l, sz, bt, 4'($urandom), nb, -1, 8'h00, $urandom_range(0, 2));
            end
        end
        do_read(48'h8000_0000, 8'd15, 3'd3, 2'd1, 4'h0, -1, 0);
        do_read(48'h8000_0080, 8'd15, 3'd3, 2'd1, 4'h0, -1, 0);
    endtask

    initial begin
        test_reset();
        test_single_read();
        test_incr_write();
        test_wrap_read();
        test_errors();
        test_backpressure();
        test_w_waits_for_aw();
        test_concurrent();
        test_reset_mid_burst();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
